// File: rtl/mips_pkg.sv
// Shared encodings for the tinymips multicycle controller:
// opcodes, funct codes, ALU controls and the FSM state type.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] F_ADD = 6'd32;
    localparam logic [5:0] F_SUB = 6'd34;
    localparam logic [5:0] F_AND = 6'd36;
    localparam logic [5:0] F_OR  = 6'd37;
    localparam logic [5:0] F_SLT = 6'd42;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTE,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEX,
        S_ADDIWB,
        S_JUMP,
        S_TRAP
    } state_t;

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath bundle: IR fields and zero flag in,
// enables, selects and status out.
interface mc_controller_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             zero;
    logic             pcen;
    logic             iord;
    logic             memwrite;
    logic             irwrite;
    logic             regdst;
    logic             memtoreg;
    logic             regwrite;
    logic             alusrca;
    logic [1:0]       alusrcb;
    logic [1:0]       pcsrc;
    logic [2:0]       alucontrol;
    logic [CNT_W-1:0] instret;
    logic             illegal;

    modport master (
        input  op, funct, zero,
        output pcen, iord, memwrite, irwrite, regdst, memtoreg,
        output regwrite, alusrca, alusrcb, pcsrc, alucontrol,
        output instret, illegal
    );

    modport slave (
        output op, funct, zero,
        input  pcen, iord, memwrite, irwrite, regdst, memtoreg,
        input  regwrite, alusrca, alusrcb, pcsrc, alucontrol,
        input  instret, illegal
    );
endinterface

// File: rtl/mc_aludec.sv
// ALU control: fixed add/sub in address/branch states,
// funct-decoded operation in EXECUTE, zero elsewhere.
module mc_aludec
    import mips_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    logic [2:0] rtype_alu;

    always_comb begin
        rtype_alu = ALU_ADD;
        case (funct)
            F_ADD:   rtype_alu = ALU_ADD;
            F_SUB:   rtype_alu = ALU_SUB;
            F_AND:   rtype_alu = ALU_AND;
            F_OR:    rtype_alu = ALU_OR;
            F_SLT:   rtype_alu = ALU_SLT;
            default: rtype_alu = ALU_ADD;
        endcase
    end

    always_comb begin
        alucontrol = 3'b000;
        case (state)
            S_FETCH,
            S_DECODE,
            S_MEMADR,
            S_ADDIEX:  alucontrol = ALU_ADD;
            S_BRANCH:  alucontrol = ALU_SUB;
            S_EXECUTE: alucontrol = rtype_alu;
            default:   alucontrol = 3'b000;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle Moore control FSM with retired-instruction counter.
// Define MC_ILLEGAL_TRAP_EN to trap unknown opcodes in a sticky TRAP state.
module mc_controller
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic            CLK,
    input  logic            RST,
    mc_controller_if.master bus
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             illegal_q, illegal_d;

    logic       pcwrite, branch;
    logic       iord, memwrite, irwrite;
    logic       regdst, memtoreg, regwrite;
    logic       alusrca;
    logic [1:0] alusrcb, pcsrc;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        case (state_q)
            S_FETCH: begin
                alusrcb = 2'b01;
                irwrite = 1'b1;
                pcwrite = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (bus.op)
                    OP_LW,
                    OP_SW:    state_d = S_MEMADR;
                    OP_RTYPE: state_d = S_EXECUTE;
                    OP_BEQ:   state_d = S_BRANCH;
                    OP_ADDI:  state_d = S_ADDIEX;
                    OP_J:     state_d = S_JUMP;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:  state_d = S_TRAP;
`else
                    default:  state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                pcsrc   = 2'b01;
                branch  = 1'b1;
                state_d = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                state_d = S_FETCH;
            end
`ifdef MC_ILLEGAL_TRAP_EN
            S_TRAP:  state_d = S_TRAP;
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // Every transition back to FETCH retires exactly one instruction.
    always_comb begin
        instret_d = instret_q;
        if (state_d == S_FETCH) instret_d = instret_q + CNT_W'(1);
`ifdef MC_ILLEGAL_TRAP_EN
        illegal_d = illegal_q | (state_d == S_TRAP);
`else
        illegal_d = 1'b0;
`endif
    end

    mc_aludec u_aludec (
        .state      (state_q),
        .funct      (bus.funct),
        .alucontrol (bus.alucontrol)
    );

    // Write-type enables are held off for the whole reset window.
    assign bus.pcen     = ~RST & (pcwrite | (branch & bus.zero));
    assign bus.irwrite  = ~RST & irwrite;
    assign bus.regwrite = ~RST & regwrite;
    assign bus.memwrite = ~RST & memwrite;
    assign bus.iord     = iord;
    assign bus.regdst   = regdst;
    assign bus.memtoreg = memtoreg;
    assign bus.alusrca  = alusrca;
    assign bus.alusrcb  = alusrcb;
    assign bus.pcsrc    = pcsrc;
    assign bus.instret  = instret_q;
    assign bus.illegal  = illegal_q;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed instruction table, random program
// against a per-instruction step model, reset-abort and illegal-op checks.
module tb_mc_controller;

    logic CLK;
    logic RST;
    int   total;
    int   bad;
    logic [31:0] exp_ir;

    mc_controller_if #(.CNT_W(32)) bus ();

    mc_controller #(.CNT_W(32)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] instr;
        int          zmode;
        int          cyc;
    } vec_t;

    // Bit order: pcen iord memwrite irwrite regdst memtoreg regwrite
    // alusrca alusrcb[1:0] pcsrc[1:0] alucontrol[2:0]
    function automatic logic [14:0] pack(
        logic pc, logic io, logic mw, logic ir, logic rd, logic mr,
        logic rw, logic sa, logic [1:0] sb, logic [1:0] ps, logic [2:0] al);
        return {pc, io, mw, ir, rd, mr, rw, sa, sb, ps, al};
    endfunction

    function automatic logic [14:0] getv();
        return pack(bus.pcen, bus.iord, bus.memwrite, bus.irwrite,
                    bus.regdst, bus.memtoreg, bus.regwrite, bus.alusrca,
                    bus.alusrcb, bus.pcsrc, bus.alucontrol);
    endfunction

    function automatic logic [2:0] falu(logic [5:0] f);
        case (f)
            6'd32:   return 3'b010;
            6'd34:   return 3'b110;
            6'd36:   return 3'b000;
            6'd37:   return 3'b001;
            6'd42:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    function automatic int cpi(logic [5:0] op);
        case (op)
            6'h23:   return 5;
            6'h2B:   return 4;
            6'h00:   return 4;
            6'h08:   return 4;
            6'h04:   return 3;
            6'h02:   return 3;
            default: return 2;
        endcase
    endfunction

    // Expected outputs in cycle k of an instruction, from the step listing.
    function automatic logic [14:0] expv(logic [5:0] op, logic [5:0] f,
                                         int k, logic z);
        if (k == 0) return pack(1, 0, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010);
        if (k == 1) return pack(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010);
        case (op)
            6'h23: begin
                if (k == 2) return pack(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010);
                if (k == 3) return pack(0,1,0,0,0,0,0,0,2'b00,2'b00,3'b000);
                if (k == 4) return pack(0,0,0,0,0,1,1,0,2'b00,2'b00,3'b000);
            end
            6'h2B: begin
                if (k == 2) return pack(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010);
                if (k == 3) return pack(0,1,1,0,0,0,0,0,2'b00,2'b00,3'b000);
            end
            6'h00: begin
                if (k == 2) return pack(0,0,0,0,0,0,0,1,2'b00,2'b00,falu(f));
                if (k == 3) return pack(0,0,0,0,1,0,1,0,2'b00,2'b00,3'b000);
            end
            6'h08: begin
                if (k == 2) return pack(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010);
                if (k == 3) return pack(0,0,0,0,0,0,1,0,2'b00,2'b00,3'b000);
            end
            6'h04: begin
                if (k == 2) return pack(z,0,0,0,0,0,0,1,2'b00,2'b01,3'b110);
            end
            6'h02: begin
                if (k == 2) return pack(1,0,0,0,0,0,0,0,2'b00,2'b10,3'b000);
            end
            default: ;
        endcase
        return 15'h7fff;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Called mid-cycle while in FETCH; returns cycles until the next FETCH.
    task automatic run_instr(logic [31:0] instr, int zmode, output int ncyc);
        logic [5:0] op;
        logic [5:0] f;
        logic       z;
        op = instr[31:26];
        f  = instr[5:0];
        bus.op    = op;
        bus.funct = f;
        ncyc = 0;
        for (int k = 0; k < 16; k++) begin
            z = (zmode == 2) ? 1'($urandom) : 1'(zmode);
            bus.zero = z;
            #1;
            if (k > 0 && bus.irwrite === 1'b1) begin
                ncyc = k;
                break;
            end
            check($sformatf("step op=%h k=%0d", op, k),
                  32'(getv()), 32'(expv(op, f, k, z)));
            @(negedge CLK);
        end
        if (ncyc == 0) check("fetch_timeout", 32'd0, 32'd1);
        exp_ir = exp_ir + 32'd1;
        check("instret", bus.instret, exp_ir);
    endtask

    localparam logic [14:0] RST_V =
        15'b0_0_0_0_0_0_0_0_01_00_010;

    vec_t vecs[$];
    int   ncyc;

    initial begin
        total = 0;
        bad = 0;
        exp_ir = 0;
        RST = 1'b1;
        bus.op = 6'h23;
        bus.funct = 6'd0;
        bus.zero = 1'b1;

        vecs.push_back('{32'h8C010004, 2, 5});
        vecs.push_back('{32'hAC010004, 2, 4});
        vecs.push_back('{32'h00011020, 2, 4});
        vecs.push_back('{32'h00011022, 2, 4});
        vecs.push_back('{32'h00011024, 2, 4});
        vecs.push_back('{32'h00011025, 2, 4});
        vecs.push_back('{32'h0001102A, 2, 4});
        vecs.push_back('{32'h00011003, 2, 4});
        vecs.push_back('{32'h2002000A, 2, 4});
        vecs.push_back('{32'h10000003, 1, 3});
        vecs.push_back('{32'h10000003, 0, 3});
        vecs.push_back('{32'h08000010, 2, 3});
`ifndef MC_ILLEGAL_TRAP_EN
        vecs.push_back('{32'hFC000000, 2, 2});
`endif

        repeat (2) @(negedge CLK);
        #1;
        check("rst_outputs", 32'(getv()), 32'(RST_V));
        check("rst_instret", bus.instret, 32'd0);
        check("rst_illegal", 32'(bus.illegal), 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        foreach (vecs[i]) begin
            run_instr(vecs[i].instr, vecs[i].zmode, ncyc);
            check($sformatf("cycles %h", vecs[i].instr), ncyc, vecs[i].cyc);
        end
        check("illegal_low", 32'(bus.illegal), 32'd0);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] ins;
            logic [5:0]  ops [7];
            logic [5:0]  fs [6];
            ops = '{6'h23, 6'h2B, 6'h00, 6'h08, 6'h04, 6'h02, 6'h3F};
            fs  = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0};
            ins = $urandom;
`ifdef MC_ILLEGAL_TRAP_EN
            ins[31:26] = ops[$urandom_range(0, 5)];
`else
            ins[31:26] = ops[$urandom_range(0, 6)];
`endif
            fs[5] = 6'($urandom);
            ins[5:0] = fs[$urandom_range(0, 5)];
            run_instr(ins, 2, ncyc);
            if (ncyc != cpi(ins[31:26]))
                check("rand_cycles", ncyc, cpi(ins[31:26]));
        end

        // Reset in the middle of an lw aborts it without retiring it.
        bus.op = 6'h23;
        bus.funct = 6'd0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        exp_ir = 0;
        #1;
        check("abort_outputs", 32'(getv()), 32'(RST_V));
        check("abort_instret", bus.instret, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        run_instr(32'h00011022, 1, ncyc);
        check("post_abort_cycles", ncyc, 4);

`ifdef MC_ILLEGAL_TRAP_EN
        bus.op = 6'h3F;
        bus.zero = 1'b1;
        #1;
        check("trap_fetch", 32'(getv()), 32'(expv(6'h3F, 6'd0, 0, 1'b1)));
        @(negedge CLK);
        #1;
        check("trap_decode", 32'(getv()), 32'(expv(6'h3F, 6'd0, 1, 1'b1)));
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            #1;
            check("trap_hold", 32'(getv()), 32'd0);
            check("trap_illegal", 32'(bus.illegal), 32'd1);
            check("trap_instret", bus.instret, exp_ir);
        end
        RST = 1'b1;
        #1;
        check("trap_clr_illegal", 32'(bus.illegal), 32'd0);
        check("trap_clr_instret", bus.instret, 32'd0);
        exp_ir = 0;
        @(negedge CLK);
        RST = 1'b0;
        run_instr(32'h08000010, 2, ncyc);
        check("post_trap_cycles", ncyc, 3);
`else
        run_instr(32'hFC00002A, 2, ncyc);
        check("nop_cycles", ncyc, 2);
        check("nop_illegal", 32'(bus.illegal), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
